// File: rtl/huffman_pkg.sv
// Shared constants, FSM state type and helpers for the Huffman encoder/decoder pair.
package huffman_pkg;
  localparam int NUM_SYM = 10;
  localparam int CODE_W  = 9;
  localparam int CNT_W   = 9;
  localparam int SYM_W   = 4;
  localparam int LEN_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } hd_state_e;

  // Mask covering the low 'len' bits of a right-aligned code.
  function automatic logic [15:0] len_mask(input logic [LEN_W-1:0] len);
    logic [16:0] m;
    m = (17'd1 << len) - 17'd1;
    return m[15:0];
  endfunction
endpackage

// File: rtl/huffman_decoder_if.sv
// Table-load, bit-stream and result signals of the Huffman decoder.
interface huffman_decoder_if #(
  parameter int CODE_W = huffman_pkg::CODE_W,
  parameter int CNT_W  = huffman_pkg::CNT_W
);
  logic                            tbl_we;
  logic [huffman_pkg::SYM_W-1:0]   tbl_sym;
  logic [CODE_W-1:0]               tbl_code;
  logic [huffman_pkg::LEN_W-1:0]   tbl_len;
  logic                            start;
  logic                            bit_valid;
  logic                            bit_in;
  logic                            stream_end;
  logic [huffman_pkg::SYM_W-1:0]   data_out;
  logic                            data_valid;
  logic [CNT_W-1:0]                sym_count;
  logic                            decode_finish;
  logic                            decode_error;

  modport master (
    output tbl_we, tbl_sym, tbl_code, tbl_len, start, bit_valid, bit_in, stream_end,
    input  data_out, data_valid, sym_count, decode_finish, decode_error
  );
  modport slave (
    input  tbl_we, tbl_sym, tbl_code, tbl_len, start, bit_valid, bit_in, stream_end,
    output data_out, data_valid, sym_count, decode_finish, decode_error
  );
endinterface

// File: rtl/huffman_match.sv
// Parallel compare of a candidate code against every table entry; lowest index wins.
module huffman_match import huffman_pkg::*; #(
  parameter int NUM_SYM = huffman_pkg::NUM_SYM,
  parameter int CODE_W  = huffman_pkg::CODE_W
) (
  input  logic [NUM_SYM-1:0][CODE_W-1:0] code_i,
  input  logic [NUM_SYM-1:0][LEN_W-1:0]  len_i,
  input  logic [CODE_W-1:0]              acc_i,
  input  logic [LEN_W-1:0]               acc_len_i,
  output logic                           hit_o,
  output logic [SYM_W-1:0]               sym_o
);
  logic [NUM_SYM-1:0] lane_hit;
  logic [CODE_W-1:0]  mask;

  assign mask = CODE_W'(len_mask(acc_len_i));

  // Bits above the code length in a table entry are don't-care.
  for (genvar g = 0; g < NUM_SYM; g++) begin : g_lane
    assign lane_hit[g] = (len_i[g] != '0) && (len_i[g] == acc_len_i) &&
                         ((code_i[g] & mask) == (acc_i & mask));
  end

  always_comb begin
    hit_o = |lane_hit;
    sym_o = '0;
    for (int i = NUM_SYM - 1; i >= 0; i--)
      if (lane_hit[i]) sym_o = SYM_W'(i);
  end
endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: loadable code table, bit accumulator, session FSM.
module huffman_decoder import huffman_pkg::*; #(
  parameter int NUM_SYM = huffman_pkg::NUM_SYM,
  parameter int CODE_W  = huffman_pkg::CODE_W,
  parameter int CNT_W   = huffman_pkg::CNT_W
) (
  input logic              clk,
  input logic              rst_n,
  huffman_decoder_if.slave bus
);
  logic [NUM_SYM-1:0][CODE_W-1:0] code_q;
  logic [NUM_SYM-1:0][LEN_W-1:0]  len_tbl_q;

  hd_state_e         state_q, state_d;
  // A full CODE_W-bit accumulator never needs storing: it either matches or errors.
  logic [CODE_W-2:0] acc_q, acc_d;
  logic [CODE_W-1:0] acc_nxt;
  logic [LEN_W-1:0]  len_q, len_d, len_nxt, res_len;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SYM_W-1:0]  dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              hit;
  logic [SYM_W-1:0]  hit_sym;
  logic              tbl_wr_ok;

  assign acc_nxt   = {acc_q, bus.bit_in};
  assign len_nxt   = len_q + 1'b1;
  assign tbl_wr_ok = bus.tbl_we && (state_q != DECODE);

  huffman_match #(.NUM_SYM(NUM_SYM), .CODE_W(CODE_W)) u_match (
    .code_i    (code_q),
    .len_i     (len_tbl_q),
    .acc_i     (acc_nxt),
    .acc_len_i (len_nxt),
    .hit_o     (hit),
    .sym_o     (hit_sym)
  );

  // Out-of-range symbol indices simply match no lane.
  for (genvar g = 0; g < NUM_SYM; g++) begin : g_tbl
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        code_q[g]    <= '0;
        len_tbl_q[g] <= '0;
      end else if (tbl_wr_ok && (bus.tbl_sym == SYM_W'(g))) begin
        code_q[g]    <= bus.tbl_code;
        len_tbl_q[g] <= bus.tbl_len;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    res_len = len_q;
    if (bus.start) begin
      state_d = DECODE;
      acc_d   = '0;
      len_d   = '0;
      cnt_d   = '0;
    end else if (state_q == DECODE) begin
      if (bus.bit_valid) begin
        if (hit) begin
          dv_d    = 1'b1;
          dout_d  = hit_sym;
          acc_d   = '0;
          len_d   = '0;
          res_len = '0;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
          acc_d   = acc_nxt[CODE_W-2:0];
          len_d   = len_nxt;
          res_len = len_nxt;
          if (len_nxt == LEN_W'(CODE_W)) state_d = ERR;
        end
      end
      // The same-cycle bit has been folded into res_len before the end rules apply.
      if (bus.stream_end && (state_d == DECODE))
        state_d = (res_len == '0) ? DONE : ERR;
    end
  end

  assign bus.data_out      = dout_q;
  assign bus.data_valid    = dv_q;
  assign bus.sym_count     = cnt_q;
  assign bus.decode_finish = (state_q == DONE);
  assign bus.decode_error  = (state_q == ERR);
endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder with hand-computed expectations.
module tb_huffman_decoder;
  import huffman_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  huffman_decoder_if bus();
  huffman_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input logic [CODE_W-1:0] c, input int l);
    bus.tbl_we = 1'b1; bus.tbl_sym = 4'(s); bus.tbl_code = c; bus.tbl_len = 4'(l);
    cyc();
    bus.tbl_we = 1'b0;
  endtask

  task automatic clr_tbl();
    for (int i = 0; i < NUM_SYM; i++) wr(i, '0, 0);
  endtask

  task automatic load_std();
    wr(0, 9'b0, 1); wr(1, 9'b10, 2); wr(2, 9'b110, 3); wr(3, 9'b111, 3);
  endtask

  task automatic go();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  task automatic sbit(input logic b, input logic e, output logic dv, output logic [3:0] d);
    bus.bit_valid = 1'b1; bus.bit_in = b; bus.stream_end = e;
    cyc();
    bus.bit_valid = 1'b0; bus.stream_end = 1'b0;
    dv = bus.data_valid; d = bus.data_out;
  endtask

  task automatic send_end();
    bus.stream_end = 1'b1; cyc(); bus.stream_end = 1'b0;
  endtask

  logic       dv;
  logic [3:0] d;
  int         ndv;

  initial begin
    logic       bits36 [6] = '{0, 1, 0, 1, 1, 0};
    logic       dv36   [6] = '{1, 0, 1, 0, 0, 1};
    logic [3:0] sym36  [6] = '{0, 0, 1, 0, 0, 2};

    bus.tbl_we = 0; bus.tbl_sym = 0; bus.tbl_code = 0; bus.tbl_len = 0;
    bus.start = 0; bus.bit_valid = 0; bus.bit_in = 0; bus.stream_end = 0;
    repeat (3) cyc();
    chk("rst data_out", bus.data_out, 0);
    chk("rst data_valid", bus.data_valid, 0);
    chk("rst sym_count", bus.sym_count, 0);
    chk("rst finish", bus.decode_finish, 0);
    chk("rst error", bus.decode_error, 0);
    rst_n = 1'b1;
    cyc();

    // Basic three-symbol stream
    load_std();
    go();
    for (int i = 0; i < 6; i++) begin
      sbit(bits36[i], 1'b0, dv, d);
      chk($sformatf("s36 dv[%0d]", i), dv, dv36[i]);
      if (dv36[i]) chk($sformatf("s36 sym[%0d]", i), d, sym36[i]);
    end
    send_end();
    chk("s36 count", bus.sym_count, 3);
    chk("s36 finish", bus.decode_finish, 1);
    chk("s36 error", bus.decode_error, 0);
    sbit(1'b0, 1'b0, dv, d);
    chk("done ignores bit dv", dv, 0);
    chk("done ignores bit cnt", bus.sym_count, 3);

    // Truncated code at stream end
    go();
    chk("start clears finish", bus.decode_finish, 0);
    chk("start clears count", bus.sym_count, 0);
    ndv = 0;
    for (int i = 0; i < 2; i++) begin sbit(1'b1, 1'b0, dv, d); ndv += int'(dv); end
    send_end();
    chk("s37 no dv", ndv, 0);
    chk("s37 error", bus.decode_error, 1);
    chk("s37 finish", bus.decode_finish, 0);
    chk("s37 count", bus.sym_count, 0);

    // Max-length code with no match
    clr_tbl();
    wr(0, 9'b0, 9);
    go();
    ndv = 0;
    for (int i = 0; i < 8; i++) begin sbit(1'b1, 1'b0, dv, d); ndv += int'(dv); end
    chk("s38 no err at 8", bus.decode_error, 0);
    sbit(1'b1, 1'b0, dv, d); ndv += int'(dv);
    chk("s38 err at 9", bus.decode_error, 1);
    chk("s38 no dv", ndv, 0);

    // Duplicate entries: lowest index wins
    clr_tbl();
    wr(4, 9'b01, 2); wr(5, 9'b01, 2);
    go();
    sbit(1'b0, 1'b0, dv, d);
    chk("s39 dv after 1st", dv, 0);
    sbit(1'b1, 1'b0, dv, d);
    chk("s39 dv", dv, 1);
    chk("s39 sym", d, 4);
    wr(0, 9'b1, 1);
    sbit(1'b1, 1'b0, dv, d);
    chk("we in decode ignored", dv, 0);
    send_end();
    chk("residual end error", bus.decode_error, 1);

    // Match completing in the stream_end cycle
    go();
    sbit(1'b0, 1'b0, dv, d);
    sbit(1'b1, 1'b1, dv, d);
    chk("end+match dv", dv, 1);
    chk("end+match sym", d, 4);
    chk("end+match finish", bus.decode_finish, 1);
    chk("end+match count", bus.sym_count, 1);

    // Reset mid-session clears table and outputs
    clr_tbl();
    load_std();
    go();
    sbit(1'b0, 1'b0, dv, d);
    sbit(1'b1, 1'b0, dv, d);
    sbit(1'b0, 1'b0, dv, d);
    chk("s40 sym before rst", d, 1);
    chk("s40 count before rst", bus.sym_count, 2);
    sbit(1'b1, 1'b0, dv, d);
    #2 rst_n = 1'b0;
    #1;
    chk("s40 rst data_out", bus.data_out, 0);
    chk("s40 rst dv", bus.data_valid, 0);
    chk("s40 rst count", bus.sym_count, 0);
    chk("s40 rst finish", bus.decode_finish, 0);
    chk("s40 rst error", bus.decode_error, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    go();
    ndv = 0;
    for (int i = 0; i < 8; i++) begin sbit(1'b0, 1'b0, dv, d); ndv += int'(dv); end
    chk("s40 no err at 8", bus.decode_error, 0);
    sbit(1'b0, 1'b0, dv, d); ndv += int'(dv);
    chk("s40 err at 9", bus.decode_error, 1);
    chk("s40 no dv", ndv, 0);

    // Counter run and saturation
    wr(0, 9'b0, 1);
    go();
    ndv = 0;
    for (int i = 0; i < 256; i++) begin sbit(1'b0, 1'b0, dv, d); ndv += int'(dv); end
    chk("s41 count 256", bus.sym_count, 256);
    chk("s41 dv 256", ndv, 256);
    for (int i = 0; i < 264; i++) sbit(1'b0, 1'b0, dv, d);
    chk("count saturates", bus.sym_count, 511);
    go();
    chk("s41 restart count", bus.sym_count, 0);
    chk("s41 restart error", bus.decode_error, 0);
    sbit(1'b0, 1'b0, dv, d);
    chk("s41 table kept dv", dv, 1);
    chk("s41 table kept sym", d, 0);
    chk("s41 count 1", bus.sym_count, 1);
    send_end();
    chk("s41 finish", bus.decode_finish, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 Parameter NUM_SYM, default 10, number of symbols (values 0..9).
REQ-002 Parameter CODE_W, default 9, maximum code length in bits.
REQ-003 Parameter CNT_W, default 9, width of the decoded-symbol counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 tbl_we  in  1  write strobe for one code-table entry.
REQ-007 tbl_sym  in  4  symbol index to write (0..NUM_SYM-1).
REQ-008 tbl_code  in  CODE_W  code value, right-aligned, MSB transmitted first.
REQ-009 tbl_len  in  4  code length 1..CODE_W; 0 marks the entry unused.
REQ-010 start  in  1  one-cycle pulse; begins a decode session.
REQ-011 bit_valid  in  1  bit_in is valid this cycle.
REQ-012 bit_in  in  1  serial code bit.
REQ-013 stream_end  in  1  one-cycle pulse; no further bits follow.
REQ-014 data_out  out  4  decoded symbol.
REQ-015 data_valid  out  1  one-cycle pulse; data_out is valid.
REQ-016 sym_count  out  CNT_W  symbols decoded in the current session.
REQ-017 decode_finish  out  1  level; session ended cleanly.
REQ-018 decode_error  out  1  level; session ended with an invalid or truncated code.

Function
REQ-019 States: IDLE, DECODE, DONE, ERR; reset state IDLE.
REQ-020 tbl_we in IDLE, DONE or ERR writes entry tbl_sym; tbl_we in DECODE is ignored; tbl_sym >= NUM_SYM is ignored.
REQ-021 start in any state clears the accumulator, bit length, sym_count, decode_finish and decode_error, then enters DECODE; table contents are kept.
REQ-022 In DECODE each bit_valid cycle shifts bit_in into the LSB of the accumulator: acc_next = {acc[CODE_W-2:0], bit_in}; length increments.
REQ-023 After each shift, acc_next and len_next are compared in parallel against every used entry; a match requires equal length and equal code.
REQ-024 On a match: data_out = matching symbol and data_valid = 1 on the next cycle (one-cycle latency after the last code bit); accumulator and length clear; sym_count increments.
REQ-025 If several entries match (malformed table), the lowest symbol index wins.
REQ-026 If len_next = CODE_W with no match: enter ERR, set decode_error, produce no data_valid.
REQ-027 stream_end with length 0 (including the cycle in which a match completes): enter DONE, set decode_finish.
REQ-028 stream_end with nonzero residual length and no completing match: enter ERR.
REQ-029 If bit_valid and stream_end occur in the same cycle, the bit is processed first, then the end rules apply.
REQ-030 sym_count saturates at 2^CNT_W-1 and does not wrap.
REQ-031 bit_valid outside DECODE is ignored; DONE and ERR are left only by start.

Reset
REQ-032 rst_n low asynchronously resets: state to IDLE; data_out, data_valid, sym_count, decode_finish and decode_error to 0; accumulator and length to 0; every table length to 0 (all entries unused).
REQ-033 Reset asserted mid-session aborts the session; no data_valid is produced until a new start.

Structure
REQ-034 NUM_SYM, CODE_W, CNT_W and the state enumeration live in a shared huffman_pkg, which the encoder also uses.
REQ-035 One sub-module, huffman_match: combinational table compare returning a hit flag and symbol index with priority to the lowest index.

Verification
REQ-036 Table {0:"0"/1, 1:"10"/2, 2:"110"/3, 3:"111"/3}; start; bits 0,1,0,1,1,0; stream_end -> data_out 0,1,2 (each one cycle after its last bit), sym_count=3, decode_finish=1.
REQ-037 Same table; bits 1,1 then stream_end -> decode_error=1, no data_valid, sym_count=0.
REQ-038 Table with only 0:"000000000"/9; bits 1×9 -> ERR on the 9th bit, decode_error=1.
REQ-039 Entries 4:"01"/2 and 5:"01"/2; bits 0,1 -> data_out=4.
REQ-040 rst_n low after 2 symbols -> all outputs 0; start with no table reload, then any 9 bits -> decode_error=1 (table cleared).
REQ-041 Decode 256 symbols of "0" -> sym_count=256; start again -> sym_count=0 with the table retained.
